seq_unsigned_divider: RTL
=========================

SEQ_UNSIGNED_DIVIDER -- requirements
Module: seq_unsigned_divider

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width (divisor and remainder are N bits; dividend and quotient are 2N bits).
REQ-002 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled on a rising clk edge.
REQ-006 dividend  input  2N  unsigned dividend (full width of an NxN product).
REQ-007 divisor  input  N  unsigned divisor.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse; results are valid.
REQ-010 quotient  output  2N  registered quotient.
REQ-011 remainder  output  N  registered remainder.
REQ-012 div_by_zero  output  1  registered flag; the last operation had divisor == 0.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL be accepted:
- latch the operands into working registers;
- clear the step counter;
- go to RUN, or go directly to DONE if divisor == 0.
REQ-015 In RUN, start SHALL be ignored, with no effect on the operation in flight.
REQ-016 In IDLE and DONE with start=0, the next state SHALL be IDLE.
REQ-017 RUN SHALL perform one restoring step per clock, MSB first, for exactly 2N clocks:
- shift the partial remainder (N+1 bits) left and bring in the next dividend bit;
- if partial ≥ divisor, subtract and set the quotient bit to 1; otherwise set it to 0.
REQ-018 After step 2N, the FSM SHALL enter DONE and load quotient, remainder and div_by_zero=0 into the output registers in the same edge.
REQ-019 Latency SHALL be fixed:
- done=1 exactly 2N+1 clocks after the accepting edge (9 clocks for N=4);
- done=1 exactly 1 clock after the accepting edge on divide-by-zero.
REQ-020 done SHALL equal (state == DONE) and be high for exactly one cycle per accepted start.
REQ-021 busy SHALL equal (state == RUN).
REQ-022 On divide-by-zero the block SHALL output quotient = all ones, remainder = dividend[N-1:0] and div_by_zero = 1.
REQ-023 Results SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor ≠ 0.
REQ-024 The output registers SHALL hold their values from done until the next done, including throughout a subsequent RUN.
REQ-025 Back-to-back operation: start=1 in the DONE cycle SHALL be accepted, with no idle cycle inserted.
REQ-026 The step counter SHALL be ceil(log2(2N+1)) bits wide, with no wrap-around within an operation.

Reset
REQ-027 rst=1 SHALL immediately, and asynchronously, force:
- state = IDLE;
- busy = 0, done = 0;
- quotient = 0, remainder = 0, div_by_zero = 0;
- counter and working registers = 0.
REQ-028 Reset during RUN SHALL abort the operation; no done pulse SHALL follow it.
REQ-029 After rst is deasserted, the first start SHALL behave per REQ-014.

Structure
REQ-030 The state encoding (IDLE=0, RUN=1, DONE=2) and the step count 2N SHALL live in a shared package or include, div_pkg.
REQ-031 The compare-subtract step SHALL be one sub-module, div_step:
- inputs: (N+1)-bit partial remainder and N-bit divisor;
- outputs: next partial remainder and quotient bit;
- purely combinational.
REQ-032 The top-level module SHALL contain only the FSM, the counter, the shift/working registers and the output registers.

Verification (N=4)
REQ-033 dividend=200, divisor=13, start pulse -> done 9 clocks later; quotient=15, remainder=5, div_by_zero=0, busy high for 8 cycles.
REQ-034 dividend=100, divisor=0 -> done 1 clock later; quotient=0xFF, remainder=4, div_by_zero=1, busy never high.
REQ-035 Boundaries:
- dividend=255, divisor=1 -> quotient=255, remainder=0;
- dividend=7, divisor=15 -> quotient=0, remainder=7;
- dividend=195, divisor=13 -> quotient=15, remainder=0.
REQ-036 Back-to-back and start during RUN:
- start 200/13, then start 50/7 in the DONE cycle -> second done 9 clocks later with quotient=7, remainder=1;
- first results held until that second done;
- start pulses during RUN are ignored.
REQ-037 rst asserted at RUN step 3 -> outputs immediately 0, no done pulse; a following start of 144/12 -> quotient=12, remainder=0.
REQ-038 Randomized sweep of all 256x16 operand pairs -> each result matches REQ-023, or REQ-022 when divisor=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the number of restoring steps per operation.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_N = 4;

    // One restoring step per dividend bit; the dividend is 2N bits wide.
    function automatic int div_steps(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor, subtract when it fits, and emit the quotient bit. Combinational.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   part_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] part_o,
    output logic         qbit_o
);

    assign qbit_o = (part_i >= {1'b0, divisor_i});

    // After the step the partial remainder is always below the divisor,
    // so it fits back into N bits.
    assign part_o = qbit_o ? N'(part_i - {1'b0, divisor_i}) : part_i[N-1:0];

endmodule

// File: rtl/seq_unsigned_divider.sv
// Sequential unsigned divider: 2N-bit dividend / N-bit divisor using one
// restoring step per clock, MSB first, with registered results.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; outputs hold the last result
// RUN     | one restoring step per clock, 2N clocks total
// DONE    | one-cycle result pulse; a new start is accepted here too
module seq_unsigned_divider import div_pkg::*; #(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int STEPS = div_steps(N);
    localparam int CW    = $clog2(STEPS + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] shf_q, shf_d;
    logic [N-1:0]   part_q, part_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [2*N-1:0] quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;

    logic [N-1:0]   step_part;
    logic           step_qbit;

    // shf_q shifts dividend bits out at the top while quotient bits enter
    // at the bottom; after 2N steps it holds the full quotient.
    div_step #(.N(N)) u_step (
        .part_i    ({part_q, shf_q[2*N-1]}),
        .divisor_i (dvs_q),
        .part_o    (step_part),
        .qbit_o    (step_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shf_q   <= '0;
            part_q  <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shf_q   <= shf_d;
            part_q  <= part_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shf_d   = shf_q;
        part_d  = part_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    shf_d  = dividend;
                    part_d = '0;
                    dvs_d  = divisor;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = dividend[N-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                shf_d  = {shf_q[2*N-2:0], step_qbit};
                part_d = step_part;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = ST_DONE;
                    quot_d  = {shf_q[2*N-2:0], step_qbit};
                    rem_d   = step_part;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
